vga_timing_gen: RTL

- Generates 640x480@60 Hz VGA raster timing in the pixel-clock domain: hsync, vsync, data-enable, pixel coordinates and line/frame strobes.
- Sits directly downstream of the VGA pixel PLL. Its clock is the PLL's 25.17 MHz output, and its `pll_locked` input is the PLL lock flag.
- Holds the raster idle until lock has been stable for a qualification window. Drops back to idle on lock loss.
- Feeds the pixel/sprite renderer and the VGA DAC pins.

---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/vga_timing_gen_if.sv | 22 ++
 rtl/vga_lock_qual.sv | 49 ++++
 rtl/vga_timing_gen.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants, total-count helpers and the
// sequencing state encoding for the VGA timing generator.
package vga_timing_pkg;

  localparam int H_ACTIVE_DEF  = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int V_ACTIVE_DEF  = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;
  localparam int LOCK_WAIT_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_QUAL = 2'd1,
    ST_RUN  = 2'd2
  } vga_state_e;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster output bundle: the generator drives it, the renderer and DAC consume it.
interface vga_timing_gen_if;
  logic       vga_hs;
  logic       vga_vs;
  logic       vga_de;
  logic       vga_blank_n;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       line_start;
  logic       frame_start;
  logic       running;

  modport master (
    output vga_hs, vga_vs, vga_de, vga_blank_n, pix_x, pix_y,
           line_start, frame_start, running
  );

  modport slave (
    input  vga_hs, vga_vs, vga_de, vga_blank_n, pix_x, pix_y,
           line_start, frame_start, running
  );
endinterface

// File: rtl/vga_lock_qual.sv
// PLL lock synchronizer plus qualification timer; lock_ok marks the cycle
// on which lock has been stable for the whole LOCK_WAIT window.
module vga_lock_qual #(
  parameter int LOCK_WAIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_locked,
  input  logic qual_en,
  output logic locked_s,
  output logic lock_ok
);

  localparam int            CW   = $clog2(LOCK_WAIT + 1);
  localparam logic [CW-1:0] LOAD = CW'(LOCK_WAIT - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] qual_cnt_q, qual_cnt_d;

  // Down-counter reloads whenever qualification is not in progress, so any
  // glitch restarts the full window.
  always_comb begin
    sync1_d    = pll_locked;
    sync2_d    = sync1_q;
    qual_cnt_d = qual_cnt_q;
    if (!qual_en || !sync2_q) begin
      qual_cnt_d = LOAD;
    end else if (qual_cnt_q != '0) begin
      qual_cnt_d = qual_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      qual_cnt_q <= LOAD;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      qual_cnt_q <= qual_cnt_d;
    end
  end

  assign locked_s = sync2_q;
  assign lock_ok  = qual_en && sync2_q && (qual_cnt_q == '0);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator, gated by PLL lock qualification.
//   state | meaning
//   IDLE  | waiting for synchronized lock, outputs at reset values
//   QUAL  | lock seen, timing the LOCK_WAIT stability window
//   RUN   | raster counters running, decode outputs live
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int LOCK_WAIT = LOCK_WAIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_locked,
  vga_timing_gen_if.master vga
);

  localparam int         H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int         V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);

  vga_state_e state_q, state_d;
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic [9:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic       line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic       running_q, running_d;
  logic       locked_s, lock_ok, qual_en, run_next;

  assign qual_en = (state_q == ST_QUAL);

  vga_lock_qual #(
    .LOCK_WAIT (LOCK_WAIT)
  ) u_lock_qual (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .qual_en    (qual_en),
    .locked_s   (locked_s),
    .lock_ok    (lock_ok)
  );

  always_comb begin
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (locked_s) state_d = ST_QUAL;
      end
      ST_QUAL: begin
        if (!locked_s) begin
          state_d = ST_IDLE;
        end else if (lock_ok) begin
          state_d = ST_RUN;
          h_cnt_d = '0;
          v_cnt_d = '0;
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d = ST_IDLE;
          h_cnt_d = '0;
          v_cnt_d = '0;
        end else if (h_cnt_q == H_LAST) begin
          h_cnt_d = '0;
          v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
        end else begin
          h_cnt_d = h_cnt_q + 10'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Decode only while staying in RUN, so the edge that leaves RUN already
  // registers the idle output levels.
  always_comb begin
    run_next      = (state_q == ST_RUN) && locked_s;
    de_d          = run_next && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hs_d          = (run_next && (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END)) ? HS_POL : ~HS_POL;
    vs_d          = (run_next && (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END)) ? VS_POL : ~VS_POL;
    pix_x_d       = de_d ? h_cnt_q : '0;
    pix_y_d       = de_d ? v_cnt_q : '0;
    line_start_d  = run_next && (h_cnt_q == '0) && (v_cnt_q < V_ACT);
    frame_start_d = run_next && (h_cnt_q == '0) && (v_cnt_q == '0);
    running_d     = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      de_q          <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      de_q          <= de_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      running_q     <= running_d;
    end
  end

  assign vga.vga_hs      = hs_q;
  assign vga.vga_vs      = vs_q;
  assign vga.vga_de      = de_q;
  assign vga.vga_blank_n = de_q;
  assign vga.pix_x       = pix_x_q;
  assign vga.pix_y       = pix_y_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;
  assign vga.running     = running_q;

endmodule
